// File: rtl/tb_base_pkg.sv
// ----------------------------------------------------------------------------
// tb_base -- shared package for the testbench memory model.
// Holds the machine/physical address widths, the widths of the per-channel
// FIFO entry fields and the entry struct used by tb_mem_chan.
// No ports (package).
// ----------------------------------------------------------------------------
package tb_base;

  // Machine and physical address widths used across the bench infrastructure.
  localparam int maBits  = 64;
  localparam int paBits  = 64;

  // Storage widths for a queued request. ADDR_W bounds the ABITS parameter of
  // the model; TIMER_W bounds LAT-1.
  localparam int ADDR_W  = maBits;
  localparam int DATA_W  = 64;
  localparam int TIMER_W = 16;

  // One outstanding request: its address (zero-extended), its error flag as
  // decided at acceptance, and the cycles left before it may be answered.
  typedef struct packed {
    logic [ADDR_W-1:0]  addr;
    logic               err;
    logic [TIMER_W-1:0] timer;
  } chan_entry_t;

endpackage

// File: rtl/tb_mem_chan.sv
// ----------------------------------------------------------------------------
// tb_mem_chan -- one channel of the latency memory model: a DEPTH-entry FIFO
// whose entries age by one every cycle and become answerable when their timer
// reaches zero. Optional error injection under macro TB_MEM_ERR_INJ_EN.
// Ports:
//   clock, reset           rising-edge clock, async active-high reset
//   req_valid/req_ready    request handshake (req_ready registered)
//   req_addr               request address (ABITS)
//   limit                  address bound; addr >= limit flags an error
//   resp_valid/resp_ready  response handshake (resp_valid registered)
//   resp_err, resp_data    response payload, zero while resp_valid is low
// ----------------------------------------------------------------------------
module tb_mem_chan
  import tb_base::*;
#(
  parameter int ABITS      = 64,
  parameter int DBITS      = 64,
  parameter int DEPTH      = 4,
  parameter int LAT        = 3,
  parameter int INJ_PERIOD = 7
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             req_valid,
  output logic             req_ready,
  input  logic [ABITS-1:0] req_addr,
  input  logic [ABITS-1:0] limit,
  output logic             resp_valid,
  input  logic             resp_ready,
  output logic             resp_err,
  output logic [DBITS-1:0] resp_data
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);
  localparam logic [TIMER_W-1:0] TIMER_INIT = TIMER_W'(LAT - 1);
  localparam logic [PW-1:0]      LAST_PTR   = PW'(DEPTH - 1);
  localparam logic [CW-1:0]      FULL_CNT   = CW'(DEPTH);

  chan_entry_t        fifo_r [DEPTH];
  chan_entry_t        fifo_s [DEPTH];
  logic [PW-1:0]      rd_ptr_r, rd_ptr_s;
  logic [PW-1:0]      wr_ptr_r, wr_ptr_s;
  logic [CW-1:0]      count_r, count_s;
  logic               req_ready_r, resp_valid_r, resp_err_r;
  logic [DBITS-1:0]   resp_data_r;
  logic               push_s, pop_s, new_err_s;
  chan_entry_t        head_s;
  logic [ABITS-1:0]   inv_addr_s;
  logic               resp_valid_s, resp_err_s;
  logic [DBITS-1:0]   resp_data_s;

  // Full blocks requests even when the head pops this same cycle.
  assign push_s = req_valid & req_ready_r;
  assign pop_s  = resp_valid_r & resp_ready;

`ifdef TB_MEM_ERR_INJ_EN
  localparam logic [15:0] INJ_LAST = 16'(INJ_PERIOD - 1);
  logic [15:0] inj_cnt_r;
  logic        inj_hit_s;

  assign inj_hit_s = (inj_cnt_r == INJ_LAST);

  // Count accepted requests modulo INJ_PERIOD.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      inj_cnt_r <= 16'd0;
    end else if (push_s) begin
      inj_cnt_r <= inj_hit_s ? 16'd0 : inj_cnt_r + 16'd1;
    end else begin
      inj_cnt_r <= inj_cnt_r;
    end
  end

  assign new_err_s = (req_addr >= limit) | inj_hit_s;
`else
  assign new_err_s = (req_addr >= limit);
`endif

  // Next FIFO state: age occupied entries, pop the head, append the request,
  // then derive the next-cycle response from the new head.
  always_comb begin
    int offset;
    offset   = 0;
    fifo_s   = fifo_r;
    rd_ptr_s = rd_ptr_r;
    wr_ptr_s = wr_ptr_r;
    count_s  = count_r;
    for (int i = 0; i < DEPTH; i++) begin
      if (i >= int'(rd_ptr_r)) begin
        offset = i - int'(rd_ptr_r);
      end else begin
        offset = i + DEPTH - int'(rd_ptr_r);
      end
      if ((offset < int'(count_r)) && (fifo_r[i].timer != {TIMER_W{1'b0}})) begin
        fifo_s[i].timer = fifo_r[i].timer - 1'b1;
      end else begin
        fifo_s[i].timer = fifo_r[i].timer;
      end
    end
    if (pop_s) begin
      rd_ptr_s = (rd_ptr_r == LAST_PTR) ? {PW{1'b0}} : rd_ptr_r + 1'b1;
    end else begin
      rd_ptr_s = rd_ptr_r;
    end
    if (push_s) begin
      // The new entry is not aged on its own acceptance edge.
      fifo_s[wr_ptr_r].addr  = ADDR_W'(req_addr);
      fifo_s[wr_ptr_r].err   = new_err_s;
      fifo_s[wr_ptr_r].timer = TIMER_INIT;
      wr_ptr_s = (wr_ptr_r == LAST_PTR) ? {PW{1'b0}} : wr_ptr_r + 1'b1;
    end else begin
      wr_ptr_s = wr_ptr_r;
    end
    case ({push_s, pop_s})
      2'b10:   count_s = count_r + 1'b1;
      2'b01:   count_s = count_r - 1'b1;
      default: count_s = count_r;
    endcase
    head_s       = fifo_s[rd_ptr_s];
    // Invert at ABITS width first so widening pads with zeros, not ones.
    inv_addr_s   = ~head_s.addr[ABITS-1:0];
    resp_valid_s = (count_s != {CW{1'b0}}) && (head_s.timer == {TIMER_W{1'b0}});
    if (resp_valid_s) begin
      resp_err_s  = head_s.err;
      resp_data_s = DBITS'(inv_addr_s);
    end else begin
      resp_err_s  = 1'b0;
      resp_data_s = {DBITS{1'b0}};
    end
  end

  // State and registered handshake/response outputs.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        fifo_r[i] <= '{addr: {ADDR_W{1'b0}}, err: 1'b0, timer: {TIMER_W{1'b0}}};
      end
      rd_ptr_r     <= {PW{1'b0}};
      wr_ptr_r     <= {PW{1'b0}};
      count_r      <= {CW{1'b0}};
      req_ready_r  <= 1'b0;
      resp_valid_r <= 1'b0;
      resp_err_r   <= 1'b0;
      resp_data_r  <= {DBITS{1'b0}};
    end else begin
      fifo_r       <= fifo_s;
      rd_ptr_r     <= rd_ptr_s;
      wr_ptr_r     <= wr_ptr_s;
      count_r      <= count_s;
      req_ready_r  <= (count_s < FULL_CNT);
      resp_valid_r <= resp_valid_s;
      resp_err_r   <= resp_err_s;
      resp_data_r  <= resp_data_s;
    end
  end

  assign req_ready  = req_ready_r;
  assign resp_valid = resp_valid_r;
  assign resp_err   = resp_err_r;
  assign resp_data  = resp_data_r;

endmodule

// File: rtl/tb_mem_model.sv
// ----------------------------------------------------------------------------
// tb_mem_model -- NCH independent fixed-latency memory channels. Each response
// carries the bitwise inverse of its request address; addresses >= limit_i
// answer with an error. Optional periodic error injection is enabled by
// defining macro TB_MEM_ERR_INJ_EN.
// Ports:
//   clock, reset                 rising-edge clock, async active-high reset
//   req_valid_i/req_ready_o      per-channel request handshake
//   req_addr_i                   channel c at [c*ABITS +: ABITS]
//   limit_i                      shared address bound
//   resp_valid_o/resp_ready_i    per-channel response handshake
//   resp_err_o                   per-channel response error
//   resp_data_o                  channel c at [c*DBITS +: DBITS]
// ----------------------------------------------------------------------------
module tb_mem_model
  import tb_base::*;
#(
  parameter int NCH        = 2,
  parameter int ABITS      = 64,
  parameter int DBITS      = 64,
  parameter int DEPTH      = 4,
  parameter int LAT        = 3,
  parameter int INJ_PERIOD = 7
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NCH-1:0]       req_valid_i,
  output logic [NCH-1:0]       req_ready_o,
  input  logic [NCH*ABITS-1:0] req_addr_i,
  input  logic [ABITS-1:0]     limit_i,
  output logic [NCH-1:0]       resp_valid_o,
  input  logic [NCH-1:0]       resp_ready_i,
  output logic [NCH-1:0]       resp_err_o,
  output logic [NCH*DBITS-1:0] resp_data_o
);

  if (LAT < 1) begin : g_lat_chk
    $error("tb_mem_model: LAT must be >= 1");
  end
  if (LAT - 1 >= (1 << TIMER_W)) begin : g_lat_max_chk
    $error("tb_mem_model: LAT too large for the entry timer");
  end
  if ((NCH < 1) || (DEPTH < 1) || (INJ_PERIOD < 1)) begin : g_size_chk
    $error("tb_mem_model: NCH, DEPTH and INJ_PERIOD must be >= 1");
  end
  if (ABITS > ADDR_W) begin : g_abits_chk
    $error("tb_mem_model: ABITS exceeds maBits");
  end

  for (genvar c = 0; c < NCH; c++) begin : g_chan
    tb_mem_chan #(
      .ABITS      (ABITS),
      .DBITS      (DBITS),
      .DEPTH      (DEPTH),
      .LAT        (LAT),
      .INJ_PERIOD (INJ_PERIOD)
    ) u_chan (
      .clock      (clock),
      .reset      (reset),
      .req_valid  (req_valid_i[c]),
      .req_ready  (req_ready_o[c]),
      .req_addr   (req_addr_i[c*ABITS +: ABITS]),
      .limit      (limit_i),
      .resp_valid (resp_valid_o[c]),
      .resp_ready (resp_ready_i[c]),
      .resp_err   (resp_err_o[c]),
      .resp_data  (resp_data_o[c*DBITS +: DBITS])
    );
  end

endmodule

// File: tb/tb_tb_mem_model.sv
// ----------------------------------------------------------------------------
// tb_tb_mem_model -- scoreboard bench for tb_mem_model (NCH=2, DEPTH=4, LAT=3,
// 64-bit address and data). Stimulus pushes the hand-computed response of each
// accepted request; a negedge monitor pops and compares on every handshake,
// checks that stalled responses hold and that idle outputs are zero.
// ----------------------------------------------------------------------------
module tb_tb_mem_model;

  localparam int NCH = 2;
`ifdef TB_MEM_ERR_INJ_EN
  localparam int INJ_PERIOD = 7;
`endif

  logic         clock = 1'b0;
  logic         reset;
  logic [1:0]   req_valid_i, req_ready_o, resp_valid_o, resp_ready_i, resp_err_o;
  logic [127:0] req_addr_i, resp_data_o;
  logic [63:0]  limit_i;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  logic [64:0] exp_q0[$];
  logic [64:0] exp_q1[$];
  logic        err_hist0[$];
  int          resp_cnt [2];
  int          first_cyc[2];
  int          last_cyc [2];
  bit          prev_stall[2];
  logic [64:0] prev_val [2];
  int          inj_cnt  [2];
  logic [64:0] mon_act, mon_exp;

  tb_mem_model #(
    .NCH(2), .ABITS(64), .DBITS(64), .DEPTH(4), .LAT(3), .INJ_PERIOD(7)
  ) dut (
    .clock        (clock),
    .reset        (reset),
    .req_valid_i  (req_valid_i),
    .req_ready_o  (req_ready_o),
    .req_addr_i   (req_addr_i),
    .limit_i      (limit_i),
    .resp_valid_o (resp_valid_o),
    .resp_ready_i (resp_ready_i),
    .resp_err_o   (resp_err_o),
    .resp_data_o  (resp_data_o)
  );

  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Expected payload of an accepted request; the injection model only exists
  // when the design is built with injection.
  task automatic push_exp(input int c, input logic [63:0] data, input logic lim_err);
    logic err;
    err = lim_err;
`ifdef TB_MEM_ERR_INJ_EN
    if (inj_cnt[c] == INJ_PERIOD - 1) begin
      err = 1'b1;
      inj_cnt[c] = 0;
    end else begin
      inj_cnt[c]++;
    end
`endif
    if (c == 0) exp_q0.push_back({err, data});
    else        exp_q1.push_back({err, data});
  endtask

  // Present one request and hold it until accepted (bounded).
  task automatic issue(input int c, input logic [63:0] addr, input logic [63:0] data,
                       input logic lim_err);
    int n;
    n = 0;
    req_valid_i[c] = 1'b1;
    req_addr_i[c*64 +: 64] = addr;
    while (req_ready_o[c] !== 1'b1 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    if (n >= 50) begin
      total++; bad++;
      $display("FAIL issue_timeout ch%0d: got ready=0 expected ready=1", c);
    end else begin
      push_exp(c, data, lim_err);
      @(posedge clock); #1;
    end
    req_valid_i[c] = 1'b0;
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while ((exp_q0.size() != 0 || exp_q1.size() != 0) && n < 200) begin
      @(posedge clock);
      n++;
    end
    #1;
    if (n >= 200) begin
      total++; bad++;
      $display("FAIL drain_timeout: got %0d/%0d pending expected 0", exp_q0.size(), exp_q1.size());
      exp_q0.delete();
      exp_q1.delete();
    end
  endtask

  // Monitor: pop/compare on handshake, hold check while stalled, zero when idle.
  always @(negedge clock) begin
    if (reset) begin
      prev_stall[0] = 1'b0;
      prev_stall[1] = 1'b0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        mon_act = {resp_err_o[c], resp_data_o[c*64 +: 64]};
        if (prev_stall[c]) begin
          check("hold_valid", resp_valid_o[c], 1'b1);
          check("hold_value", mon_act, prev_val[c]);
        end
        if (resp_valid_o[c] && resp_ready_i[c]) begin
          if ((c == 0 && exp_q0.size() == 0) || (c == 1 && exp_q1.size() == 0)) begin
            total++; bad++;
            $display("FAIL unexpected_resp ch%0d: got %0h expected none", c, mon_act);
          end else begin
            if (c == 0) mon_exp = exp_q0.pop_front();
            else        mon_exp = exp_q1.pop_front();
            check(c == 0 ? "resp_ch0" : "resp_ch1", mon_act, mon_exp);
          end
          if (resp_cnt[c] == 0) first_cyc[c] = cyc;
          last_cyc[c] = cyc;
          resp_cnt[c]++;
          if (c == 0) err_hist0.push_back(resp_err_o[0]);
          prev_stall[c] = 1'b0;
        end else if (resp_valid_o[c]) begin
          prev_stall[c] = 1'b1;
          prev_val[c]   = mon_act;
        end else begin
          prev_stall[c] = 1'b0;
          check("idle_zero", mon_act, 65'd0);
        end
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, s0, n0, n;
    reset        = 1'b1;
    req_valid_i  = 2'b00;
    req_addr_i   = 128'd0;
    resp_ready_i = 2'b00;
    limit_i      = 64'h1_0000;
    for (int c = 0; c < 2; c++) begin
      resp_cnt[c] = 0; inj_cnt[c] = 0; prev_stall[c] = 1'b0;
    end

    // Reset state.
    #1;
    check("rst_ready", req_ready_o, 2'b00);
    check("rst_valid", resp_valid_o, 2'b00);
    check("rst_err",   resp_err_o, 2'b00);
    check("rst_data",  resp_data_o, 128'd0);
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    check("ready_before_edge", req_ready_o, 2'b00);
    @(posedge clock); #1;
    check("ready_after_edge", req_ready_o, 2'b11);

    // Single request latency and payload.
    resp_ready_i = 2'b11;
    check("t1_ready", req_ready_o[0], 1'b1);
    req_valid_i[0] = 1'b1;
    req_addr_i[63:0] = 64'h1000;
    push_exp(0, 64'hFFFF_FFFF_FFFF_EFFF, 1'b0);
    @(posedge clock); #1;                     // acceptance edge t
    req_valid_i[0] = 1'b0;
    check("t1_valid_t", resp_valid_o[0], 1'b0);
    @(posedge clock); #1;                     // edge t+1
    check("t1_valid_t1", resp_valid_o[0], 1'b0);
    @(posedge clock); #1;                     // edge t+2 = t+LAT-1
    check("t1_valid_t2", resp_valid_o[0], 1'b1);
    wait_drain();

    // Fill to DEPTH under back-pressure; fifth waits, no full bypass.
    resp_ready_i = 2'b00;
    issue(0, 64'h100, 64'hFFFF_FFFF_FFFF_FEFF, 1'b0);
    issue(0, 64'h200, 64'hFFFF_FFFF_FFFF_FDFF, 1'b0);
    issue(0, 64'h300, 64'hFFFF_FFFF_FFFF_FCFF, 1'b0);
    issue(0, 64'h400, 64'hFFFF_FFFF_FFFF_FBFF, 1'b0);
    check("t2_full_ready", req_ready_o[0], 1'b0);
    req_valid_i[0] = 1'b1;
    req_addr_i[63:0] = 64'h500;
    @(posedge clock); #1;
    @(posedge clock); #1;
    check("t2_still_full", req_ready_o[0], 1'b0);
    resp_ready_i[0] = 1'b1;
    @(posedge clock); #1;                     // first pop, fifth not taken
    check("t2_ready_back", req_ready_o[0], 1'b1);
    push_exp(0, 64'hFFFF_FFFF_FFFF_FAFF, 1'b0);
    @(posedge clock); #1;                     // fifth accepted
    req_valid_i[0] = 1'b0;
    wait_drain();

    // Error flag sampled at enqueue; boundary addr == limit is an error.
    resp_ready_i = 2'b00;
    limit_i = 64'h1_0000;
    issue(1, 64'h2_0000, 64'hFFFF_FFFF_FFFD_FFFF, 1'b1);
    limit_i = 64'h3_0000;
    issue(1, 64'h2_0000, 64'hFFFF_FFFF_FFFD_FFFF, 1'b0);
    issue(1, 64'h3_0000, 64'hFFFF_FFFF_FFFC_FFFF, 1'b1);
    issue(1, 64'h2_FFFF, 64'hFFFF_FFFF_FFFD_0000, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    resp_ready_i = 2'b11;
    wait_drain();

    // Channel 0 stalled while channel 1 streams ten requests.
    resp_ready_i = 2'b10;
    issue(0, 64'hA0, 64'hFFFF_FFFF_FFFF_FF5F, 1'b0);
    issue(0, 64'hB0, 64'hFFFF_FFFF_FFFF_FF4F, 1'b0);
    resp_cnt[1] = 0;
    n0 = resp_cnt[0];
    s0 = cyc;
    t0 = 0;
    for (int k = 0; k < 10; k++) begin
      issue(1, 64'h1000 + 64'(k * 16), ~(64'h1000 + 64'(k * 16)), 1'b0);
      if (k == 0) t0 = cyc;
    end
    check("t4_input_rate", cyc - s0, 10);
    n = 0;
    while (resp_cnt[1] < 10 && n < 50) begin
      @(posedge clock); #1;
      n++;
    end
    check("t4_resp_count", resp_cnt[1], 10);
    check("t4_first_lat", first_cyc[1] - t0, 2);
    check("t4_spacing", last_cyc[1] - first_cyc[1], 9);
    check("t4_ch0_stalled", resp_cnt[0] - n0, 0);
    check("t4_ch0_valid", resp_valid_o[0], 1'b1);
    resp_ready_i = 2'b11;
    wait_drain();

    // Reset with three entries queued discards them.
    resp_ready_i = 2'b00;
    issue(0, 64'h10, 64'hFFFF_FFFF_FFFF_FFEF, 1'b0);
    issue(0, 64'h20, 64'hFFFF_FFFF_FFFF_FFDF, 1'b0);
    issue(0, 64'h30, 64'hFFFF_FFFF_FFFF_FFCF, 1'b0);
    repeat (3) @(posedge clock);
    #1;
    check("t5_valid_before", resp_valid_o[0], 1'b1);
    reset = 1'b1;
    #1;
    check("t5_valid_in_rst", resp_valid_o, 2'b00);
    check("t5_ready_in_rst", req_ready_o, 2'b00);
    check("t5_data_in_rst", resp_data_o, 128'd0);
    exp_q0.delete();
    exp_q1.delete();
    inj_cnt[0] = 0;
    inj_cnt[1] = 0;
    n0 = resp_cnt[0];
    @(posedge clock); #1;
    @(posedge clock); #1;
    reset = 1'b0;
    @(posedge clock); #1;
    check("t5_ready_after", req_ready_o, 2'b11);
    resp_ready_i = 2'b11;
    repeat (10) @(posedge clock);
    #1;
    check("t5_no_stale", resp_cnt[0] - n0, 0);

`ifdef TB_MEM_ERR_INJ_EN
    // Injection: 7th and 14th in-range responses carry err.
    limit_i = 64'hFFFF_FFFF;
    err_hist0.delete();
    for (int k = 0; k < 14; k++) begin
      issue(0, 64'(k * 8), ~(64'(k * 8)), 1'b0);
    end
    wait_drain();
    check("t6_count", err_hist0.size(), 14);
    for (int k = 0; k < 14; k++) begin
      if (k < err_hist0.size()) begin
        check("t6_inj_err", err_hist0[k], (k == 6 || k == 13) ? 1'b1 : 1'b0);
      end
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/tb_mem_model.md
TB_MEM_MODEL -- requirements
Module: tb_mem_model

Interface
REQ-001 Parameter NCH, default 2, number of independent request/response channels (>=1).
REQ-002 Parameter ABITS, default 64, request address width.
REQ-003 Parameter DBITS, default 64, response data width.
REQ-004 Parameter DEPTH, default 4, outstanding requests per channel (>=1, any integer, not only powers of two).
REQ-005 Parameter LAT, default 3, response latency in cycles (>=1; 0 rejected by elaboration assertion).
REQ-006 Parameter INJ_PERIOD, default 7, error-injection period (used only under TB_MEM_ERR_INJ_EN).
REQ-007 clock  in  1  sole clock, rising edge.
REQ-008 reset  in  1  asynchronous, active-high.
REQ-009 req_valid_i  in  NCH  per-channel request valid.
REQ-010 req_ready_o  out  NCH  per-channel request ready.
REQ-011 req_addr_i  in  NCH*ABITS  per-channel address, channel c at [c*ABITS +: ABITS].
REQ-012 limit_i  in  ABITS  address bound; addresses >= limit_i return error.
REQ-013 resp_valid_o  out  NCH  per-channel response valid.
REQ-014 resp_ready_i  in  NCH  per-channel response ready.
REQ-015 resp_err_o  out  NCH  per-channel response error.
REQ-016 resp_data_o  out  NCH*DBITS  per-channel data, channel c at [c*DBITS +: DBITS].

Function
REQ-017 Each channel SHALL own a FIFO of DEPTH entries {addr, err, timer}; channels share no state.
REQ-018 Request accepted on rising edge with req_valid_i & req_ready_o; req_ready_o = (occupancy < DEPTH); no full-bypass on simultaneous dequeue.
REQ-019 At enqueue: timer = LAT-1, err = (addr >= limit_i) sampled that cycle; limit_i changes do not affect queued entries.
REQ-020 Every cycle, every non-zero timer in every occupied entry decrements by 1; timers saturate at 0.
REQ-021 resp_valid_o = FIFO non-empty & head timer == 0; request accepted at edge t yields resp_valid_o high in the cycle after edge t+LAT-1 (LAT cycles after acceptance), given an empty queue.
REQ-022 resp_data_o = bitwise NOT of head addr, zero-extended or truncated to DBITS; resp_err_o = head err; both 0 when resp_valid_o low.
REQ-023 Once asserted, resp_valid_o, resp_data_o and resp_err_o SHALL hold until resp_valid_o & resp_ready_i; then head pops.
REQ-024 Responses SHALL return in acceptance order per channel; back-pressure on one channel SHALL NOT stall another.
REQ-025 Simultaneous enqueue and dequeue on a non-full channel keeps occupancy constant; pointers wrap from DEPTH-1 to 0.
REQ-026 Throughput: one request and one response per channel per cycle sustained when resp_ready_i held high.

Reset
REQ-027 While reset high: all FIFOs empty, pointers/occupancy/timers/injection counters 0, req_ready_o = 0, resp_valid_o = 0, resp_err_o = 0, resp_data_o = 0.
REQ-028 reset asserted mid-operation SHALL discard all outstanding requests without emitting responses; req_ready_o rises on the first edge after reset deasserts.

Configuration
REQ-029 With TB_MEM_ERR_INJ_EN defined: per-channel counter of accepted requests wraps 0..INJ_PERIOD-1; an entry enqueued while counter == INJ_PERIOD-1 has err forced to 1, regardless of limit_i.
REQ-030 Without TB_MEM_ERR_INJ_EN: no counter logic; err derives only from limit_i; INJ_PERIOD ignored.

Structure
REQ-031 Channel entry struct typedef and address/data width constants SHALL live in shared package tb_base beside maBits/paBits.
REQ-032 One sub-module tb_mem_chan (single-channel FIFO + timers + injection) SHALL be instantiated NCH times by a generate loop.

Verification
REQ-033 Single request addr 0x1000, limit 0x10000, LAT=3, ready high -> resp_valid 3 cycles after acceptance, data 0xFFFF_FFFF_FFFF_EFFF, err 0.
REQ-034 DEPTH=4, resp_ready_i low, 5 back-to-back requests -> req_ready_o low after 4th; release ready -> 4 responses in order, 5th then accepted.
REQ-035 Addr 0x20000 with limit 0x10000 -> err 1; limit raised to 0x30000 while queued -> err still 1.
REQ-036 Channel 0 stalled, channel 1 streaming 10 requests -> channel 1 returns 10 responses at 1/cycle after initial LAT.
REQ-037 Reset asserted with 3 entries queued -> resp_valid_o 0 immediately; no stale response after deassert.
REQ-038 With TB_MEM_ERR_INJ_EN, INJ_PERIOD=7, 14 in-range requests -> err 1 exactly on the 7th and 14th responses.
